// File: rtl/alu_operand_sequencer.sv
// Serialises a nibble stream (A, B, opcode) onto a 4-bit ALU and captures its result.
// Optional zero flag on the captured result when ALU_SEQ_ZFLAG_EN is defined.
module alu_operand_sequencer #(
   parameter int unsigned ISSUE_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] op,
   output logic       exec,
   input  logic [3:0] alu_v,
   output logic [3:0] res,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       busy,
`ifdef ALU_SEQ_ZFLAG_EN
   output logic       zero,
`endif
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      LD_A  = 3'd0,
      LD_B  = 3'd1,
      LD_OP = 3'd2,
      EXEC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [2:0] WAIT_LOAD = 3'(ISSUE_WAIT - 1);

   state_t     state, state_d;
   logic [2:0] cnt, cnt_d;
   logic       load_a, load_b, load_op, cap_res;

   assign dbg_state = state;

   // Handshakes: a beat moves only on a rising edge where valid && ready; valid
   // without ready is ignored, and ready never depends combinationally on valid.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      in_ready  = 1'b0;
      exec      = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_op   = 1'b0;
      cap_res   = 1'b0;
      case (state)
         LD_A: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               load_a  = 1'b1;
               state_d = LD_B;
            end
         end
         LD_B: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_b  = 1'b1;
               state_d = LD_OP;
            end
         end
         LD_OP: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_op = 1'b1;
               cnt_d   = WAIT_LOAD;
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec = 1'b1;
            if (cnt == 3'd0) begin
               cap_res = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt - 3'd1;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = LD_A;
         end
         default: state_d = LD_A;
      endcase
   end

   // clr outranks every strobe computed above, so it is handled ahead of them here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LD_A;
         cnt   <= 3'd0;
         a     <= 4'h0;
         b     <= 4'h0;
         op    <= 3'd0;
         res   <= 4'h0;
`ifdef ALU_SEQ_ZFLAG_EN
         zero  <= 1'b0;
`endif
      end else if (clr) begin
         state <= LD_A;
         cnt   <= 3'd0;
         a     <= 4'h0;
         b     <= 4'h0;
         op    <= 3'd0;
         res   <= 4'h0;
`ifdef ALU_SEQ_ZFLAG_EN
         zero  <= 1'b0;
`endif
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (load_a)  a  <= in_data;
         if (load_b)  b  <= in_data;
         if (load_op) op <= in_data[2:0];
         if (cap_res) res <= alu_v;
`ifdef ALU_SEQ_ZFLAG_EN
         if (cap_res) zero <= (alu_v == 4'h0);
`endif
      end
   end

endmodule
